shift_cmd_seq: RTL and testbench

- Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its oe, s[1:0] and d[3:0] inputs.
- Accepts one command at a time over a valid/ready handshake: load, rotate-left N, rotate-right N, or NOP.
- Expands each command into a cycle-accurate s/d sequence and pulses done when it finishes.
- Keeps a shadow copy of the register contents so control logic and the bench can read the expected q without tapping the register.

---
 rtl/shift_cmd_seq_pkg.sv | 29 ++
 rtl/shift_cmd_seq_shadow.sv | 58 +++++
 rtl/shift_cmd_seq.sv | 141 ++++++++++++++
 tb/tb_shift_cmd_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_cmd_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_cmd_seq_pkg
// Shared definitions for the shift-register command sequencer.
//   - op_t    : command opcodes. Their values are also the s[1:0] codes of
//               the downstream universal shift register, so an opcode can be
//               driven onto sr_s without any translation.
//   - state_t : sequencer FSM states.
//   - DEFAULT_WIDTH / DEFAULT_CNT_W : default data and shift-count widths.
// ---------------------------------------------------------------------------
package shift_cmd_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ROL  = 2'b01,
        OP_ROR  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_cmd_seq_shadow.sv
// ---------------------------------------------------------------------------
// shift_shadow_model
// Shadow copy of the downstream universal shift register. It is fed the same
// s/d values the register sees and updates on the same edge, so q always
// equals what the real register holds.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q and vld
//   s     : register mode (00 hold, 01 rotate left, 10 rotate right, 11 load)
//   d     : parallel load data
//   q     : modelled register contents
//   vld   : set once a load has been captured; before that the real
//           register is undefined, so q carries no meaning
// ---------------------------------------------------------------------------
module shift_shadow_model
    import shift_cmd_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    logic [WIDTH-1:0] q_next;
    logic             vld_next;

    // Next-value function of the register: rotate, load or hold.
    always_comb begin
        q_next   = q;
        vld_next = vld;
        case (s)
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_LOAD: begin
                q_next   = d;
                vld_next = 1'b1;
            end
            default: q_next = q;
        endcase
    end

    // Shadow register; reset clears it because the real register loses its
    // meaningful contents whenever the sequencer is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            q   <= q_next;
            vld <= vld_next;
        end
    end

endmodule

// File: rtl/shift_cmd_seq.sv
// ---------------------------------------------------------------------------
// shift_cmd_seq
// Command sequencer in front of the 4-bit universal shift register. Takes one
// command at a time over valid/ready, expands it into a cycle-accurate
// sr_s/sr_d sequence and pulses done at the end. A shadow model tracks the
// register contents.
// Ports:
//   clk, rst_n   : clock (rising edge) and async active-low reset
//   cmd_valid    : command present
//   cmd_ready    : sequencer can accept a command
//   cmd_op       : 00 NOP, 01 rotate left, 10 rotate right, 11 load
//   cmd_cnt      : rotate cycle count (ignored for load / NOP)
//   cmd_data     : load value (ignored for other ops)
//   sr_oe        : register output enable (1 = hi-Z), high only in reset
//   sr_s, sr_d   : register mode and parallel data
//   done         : one-cycle completion pulse
//   shadow_q     : modelled register contents
//   shadow_vld   : shadow_q meaningful (a load completed since reset)
// ---------------------------------------------------------------------------
module shift_cmd_seq
    import shift_cmd_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_oe,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_d,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q,
    output logic             shadow_vld
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       s_next;
    logic [WIDTH-1:0] d_next;
    logic             done_next;
    logic             accept;

    // Ready is decoded purely from registers, so it drops on the accepting
    // edge and stays low while the register is still hi-Z after reset.
    assign cmd_ready = (state == ST_IDLE) && !sr_oe;
    assign accept    = cmd_valid && cmd_ready;

    // Next-state and next-output logic. sr_s/done default to idle values so
    // they only assert in the cycles that need them. While shifting, the
    // rotate direction is kept in sr_s itself rather than a separate copy.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        s_next     = OP_NOP;
        d_next     = sr_d;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_next = ST_LOAD;
                            s_next     = OP_LOAD;
                            d_next     = cmd_data;
                        end
                        OP_ROL, OP_ROR: begin
                            if (cmd_cnt != '0) begin
                                state_next = ST_SHIFT;
                                s_next     = cmd_op;
                                cnt_next   = cmd_cnt;
                            end else begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                            end
                        end
                        default: begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end
            ST_SHIFT: begin
                cnt_next = cnt - 1'b1;
                if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    s_next = sr_s;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers. sr_oe holds the register in hi-Z during
    // reset and is released on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr_oe <= 1'b1;
            sr_s  <= OP_NOP;
            sr_d  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr_oe <= 1'b0;
            sr_s  <= s_next;
            sr_d  <= d_next;
            done  <= done_next;
        end
    end

    shift_shadow_model #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (sr_s),
        .d     (sr_d),
        .q     (shadow_q),
        .vld   (shadow_vld)
    );

endmodule

// File: tb/tb_shift_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_cmd_seq
// Directed testbench for shift_cmd_seq: a table of single commands with
// hand-computed results, plus hand-written sequences for reset, back-to-back
// handshakes and reset in the middle of a long rotate. A small behavioural
// model of the downstream shift register supplies the "register q" view.
// ---------------------------------------------------------------------------
module tb_shift_cmd_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       sr_oe;
    logic [1:0] sr_s;
    logic [3:0] sr_d;
    logic       done;
    logic [3:0] shadow_q;
    logic       shadow_vld;

    logic [3:0] reg_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic [3:0] data;
        logic [3:0] exp_q;
        logic       exp_vld;
        int         exp_lat;
        int         exp_act;
    } vec_t;

    vec_t vecs[8];

    shift_cmd_seq #(
        .WIDTH (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .cmd_data   (cmd_data),
        .sr_oe      (sr_oe),
        .sr_s       (sr_s),
        .sr_d       (sr_d),
        .done       (done),
        .shadow_q   (shadow_q),
        .shadow_vld (shadow_vld)
    );

    // 100 MHz style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream universal shift register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reg_q <= 4'b0000;
        else begin
            case (sr_s)
                2'b01:   reg_q <= {reg_q[2:0], reg_q[3]};
                2'b10:   reg_q <= {reg_q[0], reg_q[3:1]};
                2'b11:   reg_q <= sr_d;
                default: reg_q <= reg_q;
            endcase
        end
    end

    // Single comparison; reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Wait (bounded) for cmd_ready at a negedge sample point.
    task automatic waitReady(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: cmd_ready timeout, got 0, expected 1", name);
        end
    endtask

    // Issue one command and measure accept-to-done latency, the number of
    // cycles sr_s was non-idle, and the sr_d seen in the first cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] cnt,
                                 input logic [3:0] data, output int lat,
                                 output int act, output logic [3:0] first_d);
        waitReady("ready");
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        lat       = 0;
        act       = 0;
        first_d   = sr_d;
        while (!done && lat < 40) begin
            if (sr_s != 2'b00) act++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Run one table vector and compare everything it determines.
    task automatic runVector(input int idx, input vec_t v);
        int         lat;
        int         act;
        logic [3:0] first_d;
        applyStimulus(v.op, v.cnt, v.data, lat, act, first_d);
        checkOutput($sformatf("v%0d latency", idx), lat, v.exp_lat);
        checkOutput($sformatf("v%0d sr_s active cycles", idx), act, v.exp_act);
        checkOutput($sformatf("v%0d sr_s at done", idx), sr_s, 2'b00);
        checkOutput($sformatf("v%0d shadow_q", idx), shadow_q, v.exp_q);
        checkOutput($sformatf("v%0d shadow_vld", idx), shadow_vld, v.exp_vld);
        if (v.op == 2'b11)
            checkOutput($sformatf("v%0d sr_d during load", idx), first_d, v.data);
        if (v.exp_vld)
            checkOutput($sformatf("v%0d register q", idx), reg_q, v.exp_q);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d done pulse width", idx), done, 1'b0);
    endtask

    initial begin : main
        int  cycles;
        bit  accepted;
        bit  seen_done;
        bit  rdy;
        bit  done_seen_in_reset;

        // op, cnt, data, exp_q, exp_vld, exp_lat, exp_act
        vecs[0] = '{2'b01, 4'd2,  4'b1111, 4'b0000, 1'b0, 2,  2};
        vecs[1] = '{2'b11, 4'd0,  4'b1011, 4'b1011, 1'b1, 1,  1};
        vecs[2] = '{2'b01, 4'd3,  4'b0000, 4'b1101, 1'b1, 3,  3};
        vecs[3] = '{2'b10, 4'd0,  4'b0000, 4'b1101, 1'b1, 0,  0};
        vecs[4] = '{2'b00, 4'd5,  4'b0101, 4'b1101, 1'b1, 0,  0};
        vecs[5] = '{2'b10, 4'd2,  4'b0000, 4'b0111, 1'b1, 2,  2};
        vecs[6] = '{2'b11, 4'd9,  4'b0110, 4'b0110, 1'b1, 1,  1};
        vecs[7] = '{2'b01, 4'd15, 4'b0000, 4'b0011, 1'b1, 15, 15};

        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 4'd0;
        cmd_data  = 4'b0000;
        rst_n     = 1'b1;
        #2;
        rst_n     = 1'b0;

        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset sr_oe", sr_oe, 1'b1);
        checkOutput("reset cmd_ready", cmd_ready, 1'b0);
        checkOutput("reset sr_s", sr_s, 2'b00);
        checkOutput("reset sr_d", sr_d, 4'b0000);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset shadow_q", shadow_q, 4'b0000);
        checkOutput("reset shadow_vld", shadow_vld, 1'b0);

        // Release: oe drops on the first edge, ready follows from it.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release ready before edge", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("release sr_oe", sr_oe, 1'b0);
        checkOutput("release cmd_ready", cmd_ready, 1'b1);
        checkOutput("release sr_s", sr_s, 2'b00);

        // Table of single commands.
        for (int i = 0; i < 8; i++)
            runVector(i, vecs[i]);

        // Back-to-back: valid held high, second command must wait for done.
        waitReady("b2b ready");
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_cnt   = 4'd0;
        cmd_data  = 4'b0001;
        @(posedge clk);
        #1;
        cmd_op    = 2'b10;
        cmd_cnt   = 4'd1;
        cmd_data  = 4'b1111;
        cycles    = 0;
        accepted  = 1'b0;
        seen_done = 1'b0;
        while (!accepted && cycles < 20) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            rdy = cmd_ready;
            @(posedge clk);
            cycles++;
            if (rdy) accepted = 1'b1;
        end
        #1;
        cmd_valid = 1'b0;
        checkOutput("b2b accept spacing", cycles, 3);
        checkOutput("b2b done before second accept", seen_done, 1'b1);
        checkOutput("b2b sr_s after second accept", sr_s, 2'b10);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("b2b ror latency", cycles, 1);
        checkOutput("b2b shadow_q", shadow_q, 4'b1000);
        checkOutput("b2b register q", reg_q, 4'b1000);

        // Reset in the middle of a 15-step rotate.
        waitReady("midreset ready");
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 4'd15;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset sr_oe", sr_oe, 1'b1);
        checkOutput("midreset cmd_ready", cmd_ready, 1'b0);
        checkOutput("midreset sr_s", sr_s, 2'b00);
        checkOutput("midreset shadow_q", shadow_q, 4'b0000);
        checkOutput("midreset shadow_vld", shadow_vld, 1'b0);
        done_seen_in_reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen_in_reset = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen_in_reset = 1'b1;
        end
        checkOutput("midreset no done pulse", done_seen_in_reset, 1'b0);
        checkOutput("midreset sr_oe after release", sr_oe, 1'b0);

        // Normal operation resumes after the abort.
        runVector(8, '{2'b11, 4'd0, 4'b1010, 4'b1010, 1'b1, 1, 1});
        runVector(9, '{2'b10, 4'd1, 4'b0000, 4'b0101, 1'b1, 1, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
